// File: rtl/pad_bus_pkg.sv
// Shared definitions for the pad bus scheduler: FSM encoding, requester ids,
// bus direction codes and the width of the turnaround/latency counter.
package pad_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TURN  = 3'd1,
    ST_WR    = 3'd2,
    ST_RD    = 3'd3,
    ST_RWAIT = 3'd4
  } state_t;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  localparam int CNT_W = 3;

  // Terminal value for a counter that starts at zero and runs for n cycles.
  function automatic logic [CNT_W-1:0] cnt_last(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the losing side on every
// granted cycle so contending requesters alternate.
module rr_arb2
  import pad_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       valid,
  output logic       gnt
);

  logic ptr_r;

  // Winner selection: a lone requester wins, contention goes to the pointer.
  always_comb begin
    valid = req[0] | req[1];
    if (req[0] && req[1]) begin
      gnt = ptr_r;
    end else if (req[1]) begin
      gnt = ID1;
    end else begin
      gnt = ID0;
    end
  end

  // Pointer update, only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= ID0;
    end else if (advance && valid) begin
      ptr_r <= ~gnt;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/pad_bus_sched.sv
// Half-duplex pad bus scheduler: arbitrates two requesters, drives the pad
// bank with registered oe/data/strobe and inserts turnaround on direction change.
module pad_bus_sched
  import pad_bus_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int TURN   = 2,
  parameter int RD_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] pad_o,
  output logic             pad_oe,
  output logic             pad_stb,
  input  logic [WIDTH-1:0] pad_i
);

  localparam logic [CNT_W-1:0] TURN_LAST = cnt_last(TURN);
  localparam logic [CNT_W-1:0] RD_LAST   = cnt_last(RD_LAT);

  state_t           state_r;
  logic             id_r;
  logic             we_r;
  logic             last_dir_r;
  logic [WIDTH-1:0] wdata_r;
  logic [CNT_W-1:0] cnt_r;

  logic [1:0]       req_vec_s;
  logic             any_s;
  logic             win_s;
  logic             win_we_s;
  logic [WIDTH-1:0] win_wdata_s;
  logic             launch_s;
  logic             launch_id_s;
  logic             launch_we_s;
  logic [WIDTH-1:0] launch_wdata_s;

  // A read ack lands in an IDLE cycle while the requester still holds req;
  // masking with the ack keeps that request from being granted twice.
  assign req_vec_s = {req1 & ~ack1, req0 & ~ack0};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_vec_s),
    .advance (state_r == ST_IDLE),
    .valid   (any_s),
    .gnt     (win_s)
  );

  // Transfer attributes of the current arbitration winner.
  always_comb begin
    if (win_s == ID1) begin
      win_we_s    = we1;
      win_wdata_s = wdata1;
    end else begin
      win_we_s    = we0;
      win_wdata_s = wdata0;
    end
  end

  // Launch a WR/RD cycle straight from IDLE or at the end of turnaround.
  always_comb begin
    launch_s       = 1'b0;
    launch_id_s    = id_r;
    launch_we_s    = we_r;
    launch_wdata_s = wdata_r;
    case (state_r)
      ST_IDLE: begin
        launch_id_s    = win_s;
        launch_we_s    = win_we_s;
        launch_wdata_s = win_wdata_s;
        launch_s       = any_s && (win_we_s == last_dir_r);
      end
      ST_TURN: begin
        launch_s = (cnt_r == TURN_LAST);
      end
      default: begin
        launch_s = 1'b0;
      end
    endcase
  end

  // Scheduler FSM with registered pad controls and acknowledges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      id_r       <= ID0;
      we_r       <= 1'b0;
      wdata_r    <= {WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      last_dir_r <= DIR_RD;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= {WIDTH{1'b0}};
      pad_o      <= {WIDTH{1'b0}};
      pad_oe     <= 1'b0;
      pad_stb    <= 1'b0;
    end else begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      pad_oe  <= 1'b0;
      pad_stb <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            id_r    <= win_s;
            we_r    <= win_we_s;
            wdata_r <= win_wdata_s;
            if (!launch_s) begin
              state_r <= ST_TURN;
              cnt_r   <= {CNT_W{1'b0}};
            end
          end
        end
        ST_TURN: begin
          if (!launch_s) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_WR: begin
          state_r <= ST_IDLE;
        end
        ST_RD: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= ST_RWAIT;
        end
        ST_RWAIT: begin
          if (cnt_r == RD_LAST) begin
            rdata      <= pad_i;
            ack0       <= (id_r == ID0);
            ack1       <= (id_r == ID1);
            last_dir_r <= DIR_RD;
            state_r    <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // Write completes in its bus cycle; a read completes after RWAIT.
      if (launch_s) begin
        pad_stb <= 1'b1;
        if (launch_we_s) begin
          state_r    <= ST_WR;
          pad_oe     <= 1'b1;
          pad_o      <= launch_wdata_s;
          ack0       <= (launch_id_s == ID0);
          ack1       <= (launch_id_s == ID1);
          last_dir_r <= DIR_WR;
        end else begin
          state_r <= ST_RD;
        end
      end
    end
  end

endmodule

// File: tb/tb_pad_bus_sched.sv
// Scoreboard bench for pad_bus_sched: per-requester expectation queues, a pad
// model returning read data RD_LAT cycles after each read strobe, and bus checks.
module tb_pad_bus_sched;

  localparam int WIDTH  = 8;
  localparam int TURN   = 2;
  localparam int RD_LAT = 3;

  typedef struct packed {
    logic       we;
    logic [7:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1, we0, we1;
  logic [WIDTH-1:0] wdata0, wdata1, rdata, pad_o, pad_i;
  logic             ack0, ack1, pad_oe, pad_stb;

  exp_t       sb0[$];
  exp_t       sb1[$];
  bit         ack_log[$];
  int         ack0_times[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         stb_cyc = -100;
  int         last_wr_cyc = -100;
  int         last_rd_cyc = -100;
  int         ack_cyc0 = -1;
  int         ack_cyc1 = -1;
  logic [7:0] pad_val = 8'h00;
  exp_t       e;
  bit         mon_id;
  bit         have;

  pad_bus_sched #(.WIDTH(WIDTH), .TURN(TURN), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .pad_o(pad_o), .pad_oe(pad_oe), .pad_stb(pad_stb), .pad_i(pad_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pop on ack, direction-gap checks, pad read model.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack0 || ack1) begin
        tests++;
        if (ack0 && ack1) begin
          fails++;
          $display("FAIL ack_onehot: ack0=%0b ack1=%0b, want exactly one", ack0, ack1);
        end else begin
          mon_id = ack1;
          have = mon_id ? (sb1.size() > 0) : (sb0.size() > 0);
          if (!have) begin
            fails++;
            $display("FAIL ack_unexpected: ack on requester %0d at cycle %0d, want no ack", mon_id, cyc);
          end else begin
            if (mon_id) e = sb1.pop_front();
            else        e = sb0.pop_front();
            if (e.we) begin
              if (pad_oe !== 1'b1 || pad_stb !== 1'b1 || pad_o !== e.data) begin
                fails++;
                $display("FAIL wr_bus: oe=%0b stb=%0b pad_o=%h, want oe=1 stb=1 pad_o=%h",
                         pad_oe, pad_stb, pad_o, e.data);
              end
            end else begin
              if (pad_oe !== 1'b0 || rdata !== e.data) begin
                fails++;
                $display("FAIL rd_data: oe=%0b rdata=%h, want oe=0 rdata=%h", pad_oe, rdata, e.data);
              end
            end
          end
          if (mon_id) begin
            ack_cyc1 = cyc;
            req1 = 1'b0;
          end else begin
            ack_cyc0 = cyc;
            req0 = 1'b0;
            ack0_times.push_back(cyc);
          end
          ack_log.push_back(mon_id);
        end
      end
      if (pad_stb && !pad_oe) begin
        tests++;
        if (cyc - last_wr_cyc - 1 < TURN) begin
          fails++;
          $display("FAIL rd_gap: idle gap %0d cycles after write, want >= %0d", cyc - last_wr_cyc - 1, TURN);
        end
        last_rd_cyc = cyc;
        stb_cyc = cyc;
      end
      if (pad_oe) begin
        tests++;
        if (!pad_stb || !(ack0 || ack1) || (cyc - last_rd_cyc - 1 < TURN)) begin
          fails++;
          $display("FAIL wr_cycle: stb=%0b ack=%0b gap=%0d, want stb=1 ack=1 gap>=%0d",
                   pad_stb, ack0 | ack1, cyc - last_rd_cyc - 1, TURN);
        end
        last_wr_cyc = cyc;
      end
    end
    pad_i = (cyc == stb_cyc + RD_LAT) ? pad_val : 8'h00;
  end

  task automatic issue(input bit id, input bit we, input logic [7:0] d, output int t);
    exp_t x;
    x.we   = we;
    x.data = we ? d : pad_val;
    if (id) begin
      req1 = 1'b1; we1 = we; wdata1 = d; sb1.push_back(x);
    end else begin
      req0 = 1'b1; we0 = we; wdata0 = d; sb0.push_back(x);
    end
    t = cyc;
  endtask

  task automatic wait_free(input bit id, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if ((id ? req1 : req0) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (sb0.size() == 0 && sb1.size() == 0 && !req0 && !req1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    wdata0 = 8'h00; wdata1 = 8'h00; pad_i = 8'h00;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++; if (ack0 !== 1'b0)     begin fails++; $display("FAIL rst_ack0: got %b, want 0", ack0); end
    tests++; if (ack1 !== 1'b0)     begin fails++; $display("FAIL rst_ack1: got %b, want 0", ack1); end
    tests++; if (rdata !== 8'h00)   begin fails++; $display("FAIL rst_rdata: got %h, want 00", rdata); end
    tests++; if (pad_o !== 8'h00)   begin fails++; $display("FAIL rst_pad_o: got %h, want 00", pad_o); end
    tests++; if (pad_oe !== 1'b0)   begin fails++; $display("FAIL rst_pad_oe: got %b, want 0", pad_oe); end
    tests++; if (pad_stb !== 1'b0)  begin fails++; $display("FAIL rst_pad_stb: got %b, want 0", pad_stb); end
    #1;
  endtask

  task automatic test_read();
    int t;
    bit ok;
    pad_val = 8'hA5;
    issue(1'b0, 1'b0, 8'h00, t);
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL read_timeout: done=%0b, want 1", ok); end
    tests++; if (stb_cyc !== t + 1) begin fails++; $display("FAIL read_stb: cycle %0d, want %0d", stb_cyc, t + 1); end
    tests++; if (ack_cyc0 !== t + RD_LAT + 2) begin
      fails++; $display("FAIL read_ack: cycle %0d, want %0d", ack_cyc0, t + RD_LAT + 2);
    end
  endtask

  task automatic test_turn_write();
    int t;
    bit ok;
    issue(1'b1, 1'b1, 8'h3C, t);
    for (int i = 0; i < TURN; i++) begin
      @(negedge clk);
      tests++;
      if (pad_oe !== 1'b0 || pad_stb !== 1'b0) begin
        fails++; $display("FAIL turn_idle: oe=%b stb=%b, want 0 0", pad_oe, pad_stb);
      end
    end
    @(negedge clk);
    tests++;
    if (pad_oe !== 1'b1 || pad_o !== 8'h3C || ack1 !== 1'b1) begin
      fails++; $display("FAIL turn_wr: oe=%b pad_o=%h ack1=%b, want 1 3c 1", pad_oe, pad_o, ack1);
    end
    #1;
    wait_drain(ok);
    tests++; if (ack_cyc1 !== t + TURN + 1) begin
      fails++; $display("FAIL turn_ack: cycle %0d, want %0d", ack_cyc1, t + TURN + 1);
    end
  endtask

  task automatic test_arbitration();
    bit ok_a, ok_b, ok;
    int ta, tb;
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    ack_log.delete();
    ok_a = 1'b1; ok_b = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          wait_free(1'b0, ok); if (!ok) ok_a = 1'b0;
          issue(1'b0, 1'b1, 8'h10 + 8'(i), ta);
        end
      end
      begin
        for (int j = 0; j < 3; j++) begin
          wait_free(1'b1, ok_b);
          issue(1'b1, 1'b1, 8'h20 + 8'(j), tb);
        end
      end
    join
    wait_drain(ok);
    tests++; if (!(ok && ok_a && ok_b)) begin fails++; $display("FAIL arb_timeout: done=%0b, want 1", ok); end
    tests++; if (ack_log.size() !== 6) begin fails++; $display("FAIL arb_count: %0d acks, want 6", ack_log.size()); end
    for (int k = 0; k < ack_log.size() && k < 6; k++) begin
      tests++;
      if (ack_log[k] !== 1'(k % 2)) begin
        fails++; $display("FAIL arb_order: grant %0d went to %0d, want %0d", k, ack_log[k], k % 2);
      end
    end
  endtask

  task automatic test_dir_switch();
    bit         wes[3]   = '{1'b1, 1'b0, 1'b1};
    logic [7:0] ds[3]    = '{8'h11, 8'h5A, 8'h22};
    int         turns[3] = '{0, 1, 1};
    int t, want;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      pad_val = ds[i];
      issue(1'b0, wes[i], ds[i], t);
      wait_drain(ok);
      want = t + turns[i] * TURN + (wes[i] ? 1 : RD_LAT + 2);
      tests++;
      if (!ok || ack_cyc0 !== want) begin
        fails++; $display("FAIL dir_ack%0d: cycle %0d, want %0d", i, ack_cyc0, want);
      end
    end
  endtask

  task automatic test_reset_rwait();
    int t;
    bit ok, found;
    pad_val = 8'h99;
    issue(1'b0, 1'b0, 8'h00, t);
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (pad_stb && !pad_oe) begin found = 1'b1; break; end
    end
    tests++; if (!found) begin fails++; $display("FAIL rst_rd_stb: strobe seen=%0b, want 1", found); end
    @(negedge clk);
    #1 reset = 1'b1; req0 = 1'b0; sb0.delete();
    @(negedge clk);
    tests++; if (pad_oe !== 1'b0)  begin fails++; $display("FAIL rw_oe: got %b, want 0", pad_oe); end
    tests++; if (pad_stb !== 1'b0) begin fails++; $display("FAIL rw_stb: got %b, want 0", pad_stb); end
    tests++; if (ack0 !== 1'b0)    begin fails++; $display("FAIL rw_ack0: got %b, want 0", ack0); end
    tests++; if (rdata !== 8'h00)  begin fails++; $display("FAIL rw_rdata: got %h, want 00", rdata); end
    #1 reset = 1'b0;
    repeat (RD_LAT + 3) begin
      @(negedge clk);
      tests++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
        fails++; $display("FAIL rw_no_ack: ack0=%b ack1=%b, want 0 0", ack0, ack1);
      end
    end
    #1;
    pad_val = 8'hC3;
    issue(1'b0, 1'b0, 8'h00, t);
    wait_drain(ok);
    tests++; if (!ok || ack_cyc0 !== t + RD_LAT + 2) begin
      fails++; $display("FAIL rw_next_read: cycle %0d, want %0d", ack_cyc0, t + RD_LAT + 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ds[4] = '{8'h81, 8'h42, 8'h24, 8'h18};
    int t;
    bit ok, all_ok;
    all_ok = 1'b1;
    ack0_times.delete();
    for (int i = 0; i < 4; i++) begin
      wait_free(1'b0, ok); if (!ok) all_ok = 1'b0;
      issue(1'b0, 1'b1, ds[i], t);
    end
    wait_drain(ok);
    tests++; if (!(ok && all_ok) || ack0_times.size() !== 4) begin
      fails++; $display("FAIL b2b_count: %0d acks, want 4", ack0_times.size());
    end
    for (int i = 1; i < ack0_times.size(); i++) begin
      tests++;
      if (ack0_times[i] - ack0_times[i-1] !== 2) begin
        fails++; $display("FAIL b2b_spacing: %0d cycles, want 2", ack0_times[i] - ack0_times[i-1]);
      end
    end
    @(negedge clk);
    tests++;
    if (pad_o !== 8'h18 || pad_oe !== 1'b0) begin
      fails++; $display("FAIL b2b_hold: pad_o=%h oe=%b, want 18 0", pad_o, pad_oe);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_turn_write();
    test_arbitration();
    test_dir_switch();
    test_reset_rwait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/pad_bus_sched.md
# pad_bus_sched

Two-requester scheduler for a half-duplex parallel bus built from a bank of registered bidirectional pads (data) plus one registered output pad (strobe). It arbitrates single-word read/write transfers round-robin, drives the pad bank's output-enable and output data, and inserts turnaround cycles whenever bus direction changes. It returns read data after the pads' fixed register latency. It sits between internal masters and the pad ring; pad registers are external to this block.

## Interface
- `WIDTH`, 8: data bus width.
- `TURN`, 2: idle cycles (oe=0, stb=0) inserted on any direction change; legal range 1..7.
- `RD_LAT`, 3: cycles from the strobe cycle to the cycle in which `pad_i` carries read data; legal range 1..7.

Ports (clock and reset first):
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  transfer request; held until the matching ack.
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while req is high.
- `wdata0` / `wdata1`  in  WIDTH  write data; valid while req is high.
- `ack0` / `ack1`  out  1  one-cycle pulse marking transfer completion.
- `rdata`  out  WIDTH  read data; valid when `ack0` or `ack1` pulses for a read.
- `pad_o`  out  WIDTH  data to the pad output registers.
- `pad_oe`  out  1  output enable to the pad bank, shared by all bits.
- `pad_stb`  out  1  strobe to the output pad register.
- `pad_i`  in  WIDTH  data from the pad input registers.

## Operation
- Reset values: all acks 0, `rdata` 0, `pad_o` 0, `pad_oe` 0, `pad_stb` 0, state IDLE, last direction = read, round-robin pointer = 0.
- States and transitions:
  - IDLE:
    - No request: stay in IDLE.
    - Request present: arbitrate, then latch the winner's id, `we`, and `wdata`.
    - Latched direction differs from last direction: go to TURN.
    - Otherwise: go to WR (we=1) or RD (we=0).
  - TURN: count `TURN` cycles with `pad_oe`=0 and `pad_stb`=0, then go to WR or RD.
  - WR: 1 cycle with `pad_oe`=1, `pad_o`=latched wdata, `pad_stb`=1; ack the winner in the same cycle; last direction = write; go to IDLE.
  - RD: 1 cycle with `pad_oe`=0 and `pad_stb`=1; load the latency counter; go to RWAIT.
  - RWAIT: count `RD_LAT`. In the cycle the count expires, capture `pad_i` into `rdata` registered, pulse ack next cycle with `rdata` valid; last direction = read; go to IDLE.
- Arbitration: with one request, that requester wins. With both, the pointer selects the winner, and the pointer then points at the loser. The pointer updates only on grant.
- Requests are sampled only in IDLE. A requester must not drop req or change we/wdata before its ack; behaviour otherwise is undefined.
- `pad_o` holds its last written value when not writing. It never changes while `pad_oe`=1 except at a WR cycle.
- Counters are 3 bits wide and compare against parameter-1. Parameters outside the legal ranges are illegal and are not checked.

## Timing
- Same-direction write: req seen in IDLE at cycle t, WR at t+1, `ack` at t+1. Back-to-back writes by one requester take one transfer per 2 cycles.
- Direction change adds exactly `TURN` cycles before WR/RD.
- Read: RD (stb) at cycle s, `pad_i` sampled at s+RD_LAT, ack and `rdata` at s+RD_LAT+1. Same-direction read total: req at t, ack at t+RD_LAT+2.
- `pad_oe` is 0 for at least `TURN` cycles between any WR cycle and any RD strobe, and vice versa.
- Reset asserted mid-transfer: the next cycle is IDLE with all outputs at reset values. A pending read is discarded with no ack, and last direction = read.

## Structure
- Package `pad_bus_pkg`: state encoding (IDLE, TURN, WR, RD, RWAIT), requester-id constants, counter width.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with a pointer that advances on grant. All other logic is in the top level.

## Test plan
- Reset, then idle: all outputs 0. Single read by req0 with RD_LAT=3 and `pad_i`=8'hA5 at s+3: `ack0` at s+4 with `rdata`=A5, no turnaround inserted.
- req1 write 8'h3C after a read: exactly 2 TURN cycles with oe=0, then WR with `pad_oe`=1, `pad_o`=3C, `ack1` in the same cycle.
- Both requesters request simultaneously from reset: req0 acked first, then req1. Repeat: req1 first, alternating.
- Write, then read, then write: oe=0 gap ≥ `TURN` on both edges, and stb never asserted while oe disagrees with the transfer direction.
- Reset during RWAIT: no ack produced, `pad_oe`=0 next cycle. A subsequent read incurs no TURN.
- req0 four back-to-back writes with req1 idle: acks every 2 cycles, `pad_oe` stays 1 only in WR cycles.
